e_mdu_hilo: RTL and testbench
=============================

// Module: e_mdu_hilo
// PURPOSE
//  HI/LO control stage directly downstream of the EX-stage multiply/divide datapath. It decodes
//  the 4-bit MDU op, issues a start pulse and signedness/kind to the datapath, and counts a fixed
//  latency. It captures the 64-bit result on res_valid and commits it to the architectural HI/LO
//  pair. It also serves mthi/mtlo/mfhi/mflo and raises stall for the pipeline interlock.
// PARAMETERS
//  WIDTH    32  data width of A, B, HI, LO
//  MUL_LAT  5   busy cycles for mult/multu (>=2)
//  DIV_LAT  10  busy cycles for div/divu (>=2)
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-low reset
//  req        in   1      exception/flush: suppresses issue of the op present this cycle
//  sel        in   4      op: 1 mult,2 multu,3 div,4 divu,5 mfhi,6 mflo,7 mthi,8 mtlo; others no-op
//  A, B       in   WIDTH  rs/rt operands
//  dp_start   out  1      one-cycle start to datapath (combinational, = issue)
//  dp_signed  out  1      1 for mult/div (valid with dp_start)
//  dp_isdiv   out  1      1 for div/divu (valid with dp_start)
//  res_valid  in   1      datapath result strobe
//  res_hi     in   WIDTH  datapath HI result (remainder for div)
//  res_lo     in   WIDTH  datapath LO result (quotient for div)
//  hi, lo     out  WIDTH  architectural HI/LO
//  rd_data    out  WIDTH  mfhi->hi, mflo->lo, else 0 (combinational)
//  busy       out  1      operation in flight
//  stall      out  1      = (busy | issue) & sel in 1..8
//  err        out  1      sticky: latency expired without res_valid
// BEHAVIOUR
//  - Reset (reset=0, async): hi=lo=0, busy=0, err=0, state IDLE, counter=0, temps=0.
//  - States: IDLE, RUN. issue = IDLE & sel in {1..4} & !req.
//  - Issue at cycle T: dp_start=1 in T. At the T edge: state->RUN, cnt=MUL_LAT or DIV_LAT,
//    busy=1, pending=0. busy is high T+1..T+LAT.
//  - RUN, each edge: cnt<=cnt-1. If res_valid: tmp<={res_hi,res_lo}, pending=1. A later strobe
//    overwrites the earlier one.
//  - RUN with cnt==1 at an edge (end of cycle T+LAT): if pending or res_valid, {hi,lo} takes the
//    newest result. Else err<=1 and hi/lo are unchanged. state->IDLE and busy<=0 (low from T+LAT+1).
//  - div/divu with B==0: issue still occurs and latency runs. dp_start is suppressed, no commit,
//    hi/lo unchanged, err not set.
//  - req while RUN does not cancel. The in-flight op completes and commits.
//  - res_valid in IDLE is ignored.
//  - mthi/mtlo: write hi/lo from A at the edge only if IDLE & !req. If busy, stall=1, no write,
//    and the op is retried by the held pipeline.
//  - mfhi/mflo: rd_data always reflects current hi/lo. The pipeline honours stall while busy.
//  - A new mult/div is accepted only in IDLE. It may issue in the first cycle after busy falls.
//  - Simultaneous commit edge and res_valid: res_valid data wins.
//  - Reset mid-RUN: immediate return to IDLE and loss of the in-flight result.
//  - err is cleared only by reset.
// TESTING
//  1 mult A=-3,B=7, res_valid at T+3 {FFFFFFFF,FFFFFFEB} -> busy T+1..T+5, hi/lo committed at
//    T+5 edge, busy=0 at T+6.
//  2 divu A=100,B=7, DIV_LAT=10, res at T+9 {2,14} -> hi=2, lo=14 after T+10. stall=1 throughout
//    for sel=mflo during busy.
//  3 div B=0 with hi/lo preloaded via mthi 5, mtlo 6 -> no dp_start, busy 10 cycles, hi=5, lo=6,
//    err=0.
//  4 mult with req=1 in issue cycle -> dp_start=0, busy stays 0. mtlo with req=1 -> lo unchanged.
//  5 mult and no res_valid ever -> err=1 at T+6, hi/lo unchanged. Next mult commits normally;
//    err stays 1.
//  6 reset=0 asserted asynchronously mid-RUN (cnt=3) -> busy/hi/lo/err=0 without a clock edge.
//    New op is accepted after release.

Source files
------------

// File: rtl/e_mdu_hilo.sv
// HI/LO control stage behind the multiply/divide datapath: issues ops, times the fixed
// latency, commits the newest datapath result to HI/LO and serves mthi/mtlo/mfhi/mflo.
module e_mdu_hilo #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic [3:0]       sel,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             dp_start,
    output logic             dp_signed,
    output logic             dp_isdiv,
    input  logic             res_valid,
    input  logic [WIDTH-1:0] res_hi,
    input  logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             stall,
    output logic             err
);
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    typedef enum logic {IDLE, RUN} state_e;

    state_e             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic               pending;
    logic               div_zero;
    logic [2*WIDTH-1:0] tmp;
    logic               op_mul, op_div, op_any, issue, last;

    always_comb begin
        op_mul = (sel == 4'd1) || (sel == 4'd2);
        op_div = (sel == 4'd3) || (sel == 4'd4);
        op_any = (sel >= 4'd1) && (sel <= 4'd8);
        issue  = (state == IDLE) && (op_mul || op_div) && !req;
        last   = (state == RUN) && (cnt == CW'(1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (issue) state_nxt = RUN;
            RUN:     if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == RUN);
        // divide-by-zero still occupies the unit for the full latency, but the datapath is not started
        dp_start  = issue && !(op_div && (B == '0));
        dp_signed = issue && ((sel == 4'd1) || (sel == 4'd3));
        dp_isdiv  = issue && op_div;
        stall     = (busy || issue) && op_any;
        rd_data   = '0;
        if (sel == 4'd5)      rd_data = hi;
        else if (sel == 4'd6) rd_data = lo;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            pending  <= 1'b0;
            div_zero <= 1'b0;
            tmp      <= '0;
            hi       <= '0;
            lo       <= '0;
            err      <= 1'b0;
        end else if (state == IDLE) begin
            if (issue) begin
                cnt      <= op_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
                pending  <= 1'b0;
                div_zero <= op_div && (B == '0);
            end else if (!req && (sel == 4'd7)) begin
                hi <= A;
            end else if (!req && (sel == 4'd8)) begin
                lo <= A;
            end
        end else begin
            cnt <= cnt - CW'(1);
            if (res_valid) begin
                tmp     <= {res_hi, res_lo};
                pending <= 1'b1;
            end
            // a strobe on the final cycle is newer than anything held in tmp
            if (last && !div_zero) begin
                if (res_valid)    {hi, lo} <= {res_hi, res_lo};
                else if (pending) {hi, lo} <= tmp;
                else              err      <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_e_mdu_hilo.sv
// Scoreboard bench for e_mdu_hilo: the bench plays the datapath, predicts HI/LO/err from
// plain arithmetic and a monitor checks each completion and each mfhi/mflo read.
module tb_e_mdu_hilo;
    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic        clk = 1'b0;
    logic        reset, req, res_valid;
    logic [3:0]  sel;
    logic [31:0] A, B, res_hi, res_lo;
    logic        dp_start, dp_signed, dp_isdiv, busy, stall, err;
    logic [31:0] hi, lo, rd_data;

    e_mdu_hilo #(.WIDTH(32), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .reset(reset), .req(req), .sel(sel), .A(A), .B(B),
        .dp_start(dp_start), .dp_signed(dp_signed), .dp_isdiv(dp_isdiv),
        .res_valid(res_valid), .res_hi(res_hi), .res_lo(res_lo),
        .hi(hi), .lo(lo), .rd_data(rd_data), .busy(busy), .stall(stall), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        err;
        int          lat;
    } done_t;

    done_t       done_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] m_hi = '0, m_lo = '0;
    logic        m_err = 1'b0;
    int          n_cmp = 0, n_bad = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        r = '0;
        case (op)
            4'd1: r = 64'(longint'($signed(a)) * longint'($signed(b)));
            4'd2: r = {32'b0, a} * {32'b0, b};
            4'd3: if (b != 0) r = {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
            4'd4: if (b != 0) r = {a % b, a / b};
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic idle_noise();
        res_valid = ($urandom_range(0, 1) == 1);
        res_hi    = $urandom;
        res_lo    = $urandom;
    endtask

    task automatic wr(input logic [3:0] op, input logic [31:0] a, input bit rq);
        sel = op; A = a; B = $urandom; req = rq;
        idle_noise();
        if (!rq) begin
            if (op == 4'd7) m_hi = a;
            else            m_lo = a;
        end
        @(negedge clk);
        chk("stall_mt", stall, 0);
        chk("start_mt", dp_start, 0);
        @(posedge clk); #1;
        sel = 4'd0; req = 1'b0; res_valid = 1'b0;
    endtask

    task automatic rd(input logic [3:0] op);
        sel = op; req = 1'b0;
        idle_noise();
        rd_q.push_back(op == 4'd5 ? m_hi : m_lo);
        @(posedge clk); #1;
        sel = 4'd0; res_valid = 1'b0;
    endtask

    // k1/k2: busy-cycle indices (1..lat) of datapath strobes, 0 = none; the last strobe carries the true result
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input bit rq,
                         input int k1, input int k2, input int bsel);
        int          lat;
        bit          isdiv, isz;
        logic [63:0] good;
        done_t       d;
        isdiv = (op == 4'd3) || (op == 4'd4);
        lat   = isdiv ? DIV_LAT : MUL_LAT;
        isz   = isdiv && (b == 0);
        good  = ref_result(op, a, b);
        sel = op; A = a; B = b; req = rq;
        idle_noise();
        if (!rq) begin
            if (!isz && (k1 != 0)) begin
                m_hi = good[63:32];
                m_lo = good[31:0];
            end
            if (!isz && (k1 == 0)) m_err = 1'b1;
            d.hi = m_hi; d.lo = m_lo; d.err = m_err; d.lat = lat;
            done_q.push_back(d);
        end
        @(negedge clk);
        chk("dp_start", dp_start, !rq && !isz);
        chk("stall_issue", stall, !rq);
        if (!rq && !isz) begin
            chk("dp_signed", dp_signed, (op == 4'd1) || (op == 4'd3));
            chk("dp_isdiv", dp_isdiv, isdiv);
        end
        @(posedge clk); #1;
        if (rq) begin
            sel = 4'd0; req = 1'b0; res_valid = 1'b0;
            @(negedge clk);
            chk("busy_after_req", busy, 0);
            @(posedge clk); #1;
            return;
        end
        for (int c = 1; c <= lat; c++) begin
            sel = (bsel < 0) ? 4'($urandom_range(0, 8)) : 4'(bsel);
            A   = $urandom;
            B   = $urandom;
            req = ($urandom_range(0, 3) == 0);
            res_valid = (c == k1) || (c == k2);
            if ((c == k2) || ((c == k1) && (k2 == 0))) {res_hi, res_lo} = good;
            else {res_hi, res_lo} = {$urandom, $urandom};
            @(posedge clk); #1;
        end
        sel = 4'd0; req = 1'b0; res_valid = 1'b0;
    endtask

    // monitor: one completion per busy window, one read per idle mfhi/mflo cycle
    initial begin
        int    bcnt;
        bit    bprev;
        done_t d;
        bcnt = 0; bprev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                bcnt = 0; bprev = 1'b0;
            end else begin
                if (busy) begin
                    bcnt++;
                    chk("stall_busy", stall, (sel >= 4'd1) && (sel <= 4'd8));
                    chk("no_start_busy", dp_start, 0);
                end else if (bprev) begin
                    if (done_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_done: got busy fall expected none (t=%0t)", $time);
                    end else begin
                        d = done_q.pop_front();
                        chk("done_hi", hi, d.hi);
                        chk("done_lo", lo, d.lo);
                        chk("done_err", err, d.err);
                        chk("busy_len", 64'(bcnt), 64'(d.lat));
                    end
                    bcnt = 0;
                end
                if (!busy && ((sel == 4'd5) || (sel == 4'd6))) begin
                    if (rd_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_read: got read expected none (t=%0t)", $time);
                    end else begin
                        chk("rd_data", rd_data, rd_q.pop_front());
                    end
                end
                bprev = busy;
            end
        end
    end

    initial begin
        int          lat, r, k1, k2;
        logic [3:0]  op;
        logic [31:0] a, b;
        reset = 1'b0; req = 1'b0; sel = 4'd0; A = '0; B = '0;
        res_valid = 1'b0; res_hi = '0; res_lo = '0;
        #1;
        chk("rst_hi", hi, 0); chk("rst_lo", lo, 0);
        chk("rst_busy", busy, 0); chk("rst_err", err, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        do_op(4'd1, 32'hFFFF_FFFD, 32'd7, 1'b0, 3, 0, -1);       // mult -3*7
        rd(4'd5); rd(4'd6);
        do_op(4'd4, 32'd100, 32'd7, 1'b0, 9, 0, 6);               // divu, mflo held during busy
        rd(4'd5); rd(4'd6);
        wr(4'd7, 32'd5, 1'b0); wr(4'd8, 32'd6, 1'b0);
        do_op(4'd3, 32'd123, 32'd0, 1'b0, 4, 0, -1);              // div by zero
        rd(4'd5); rd(4'd6);
        do_op(4'd1, 32'd9, 32'd9, 1'b1, 2, 0, -1);                // flushed issue
        wr(4'd8, 32'hDEAD_BEEF, 1'b1);
        rd(4'd6);
        do_op(4'd1, 32'd11, 32'd13, 1'b0, 0, 0, -1);              // no strobe -> err
        do_op(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 5, 0, -1);        // commit, err stays
        do_op(4'd3, 32'hFFFF_FF9C, 32'd7, 1'b0, 2, 7, -1);        // two strobes, newest wins
        rd(4'd5); rd(4'd6);

        // asynchronous reset in the middle of a multiply
        sel = 4'd1; A = $urandom; B = $urandom; req = 1'b0;
        @(posedge clk); #1; sel = 4'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("busy_pre_rst", busy, 1);
        #2 reset = 1'b0;
        #1;
        chk("arst_busy", busy, 0); chk("arst_hi", hi, 0);
        chk("arst_lo", lo, 0); chk("arst_err", err, 0);
        m_hi = '0; m_lo = '0; m_err = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        do_op(4'd2, 32'd1234, 32'd5678, 1'b0, 1, 0, -1);
        rd(4'd5); rd(4'd6);

        for (int i = 0; i < 80; i++) begin
            op = 4'($urandom_range(1, 8));
            a  = $urandom;
            b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ((op == 4'd3) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) b = 32'd1;
            if (op <= 4'd4) begin
                lat = (op >= 4'd3) ? DIV_LAT : MUL_LAT;
                r = $urandom_range(0, 7);
                k2 = 0;
                if (r == 0)      k1 = 0;
                else if (r <= 4) k1 = $urandom_range(1, lat);
                else if (r == 5) k1 = lat;
                else begin
                    k1 = $urandom_range(1, lat - 1);
                    k2 = $urandom_range(k1 + 1, lat);
                end
                do_op(op, a, b, ($urandom_range(0, 7) == 0), k1, k2, -1);
            end else if (op <= 4'd6) begin
                rd(op);
            end else begin
                wr(op, a, ($urandom_range(0, 3) == 0));
            end
        end
        rd(4'd5); rd(4'd6);

        for (int w = 0; w < 40 && (done_q.size() != 0 || rd_q.size() != 0); w++) @(posedge clk);
        if (done_q.size() != 0 || rd_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain: got %0d items left expected 0", done_q.size() + rd_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
